// File: rtl/exc_collect_if.sv
// Pipeline <-> exception collector bundle: ID/EXE flags in, CP0 request out.
// int_pending/status_ie exist only when EXC_INT_EN is defined.
interface exc_collect_if;
    logic        stall;
    logic        id_valid;
    logic [31:0] id_pc;
    logic        id_pc_misalign;
    logic        id_ri;
    logic        id_syscall;
    logic        id_break;
    logic        exe_overflow;
    logic        exe_adel;
    logic        exe_ades;
    logic [31:0] exe_addr;
    logic        eret;
    logic        exc_ack;
`ifdef EXC_INT_EN
    logic [5:0]  int_pending;
    logic        status_ie;
`endif
    logic        exc_req;
    logic [4:0]  exc_code;
    logic [31:0] exc_epc;
    logic [31:0] exc_badvaddr;
    logic        exc_bad_we;
    logic        exc_flush;
    logic        eret_req;
    logic [1:0]  exc_state;

    modport master (
`ifdef EXC_INT_EN
        output int_pending, output status_ie,
`endif
        output stall, output id_valid, output id_pc, output id_pc_misalign,
        output id_ri, output id_syscall, output id_break,
        output exe_overflow, output exe_adel, output exe_ades, output exe_addr,
        output eret, output exc_ack,
        input  exc_req, input exc_code, input exc_epc, input exc_badvaddr,
        input  exc_bad_we, input exc_flush, input eret_req, input exc_state
    );

    modport slave (
`ifdef EXC_INT_EN
        input  int_pending, input status_ie,
`endif
        input  stall, input id_valid, input id_pc, input id_pc_misalign,
        input  id_ri, input id_syscall, input id_break,
        input  exe_overflow, input exe_adel, input exe_ades, input exe_addr,
        input  eret, input exc_ack,
        output exc_req, output exc_code, output exc_epc, output exc_badvaddr,
        output exc_bad_we, output exc_flush, output eret_req, output exc_state
    );
endinterface

// File: rtl/exc_collect.sv
// Exception collection ahead of CP0: one-entry EXE slot, per-instruction priority, req/drain FSM.
// Define EXC_INT_EN to add the external-interrupt request path.
//   state | meaning
//   IDLE  | collecting; slot loads from ID, EXE resolves
//   REQ   | request held to CP0 until exc_ack, pipeline flushed
//   DRAIN | flush tail for FLUSH_CYCLES after ack, slot held empty
module exc_collect #(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input logic          clk,
    input logic          reset,
    exc_collect_if.slave bus
);
    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0a;
    localparam logic [4:0] EXC_OV   = 5'h0c;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;

    logic        slot_valid, slot_exc, slot_bad_we;
    logic [31:0] slot_pc, slot_badv;
    logic [4:0]  slot_code;

    logic        id_exc;
    logic [4:0]  id_code;
    logic [31:0] id_badv;

    logic        eval, res_exc, res_bad_we, int_hit, take, eret_fire;
    logic [4:0]  res_code;
    logic [31:0] res_badv;

    logic [4:0]  code_q;
    logic [31:0] epc_q, badv_q;
    logic        bad_we_q, eret_q;

    always_comb begin
        id_exc  = 1'b0;
        id_code = EXC_INT;
        id_badv = 32'd0;
        if (bus.id_pc_misalign) begin
            id_exc  = 1'b1;
            id_code = EXC_ADEL;
            id_badv = bus.id_pc;
        end else if (bus.id_ri) begin
            id_exc  = 1'b1;
            id_code = EXC_RI;
        end else if (bus.id_syscall) begin
            id_exc  = 1'b1;
            id_code = EXC_SYS;
        end else if (bus.id_break) begin
            id_exc  = 1'b1;
            id_code = EXC_BP;
        end
    end

    assign eval = slot_valid && !bus.stall && (state_q == ST_IDLE);

    // An exception carried from ID always outranks anything raised in EXE.
    always_comb begin
        res_exc    = 1'b0;
        res_code   = EXC_INT;
        res_badv   = 32'd0;
        res_bad_we = 1'b0;
        if (slot_exc) begin
            res_exc    = 1'b1;
            res_code   = slot_code;
            res_badv   = slot_badv;
            res_bad_we = slot_bad_we;
        end else if (bus.exe_overflow) begin
            res_exc  = 1'b1;
            res_code = EXC_OV;
        end else if (bus.exe_adel) begin
            res_exc    = 1'b1;
            res_code   = EXC_ADEL;
            res_badv   = bus.exe_addr;
            res_bad_we = 1'b1;
        end else if (bus.exe_ades) begin
            res_exc    = 1'b1;
            res_code   = EXC_ADES;
            res_badv   = bus.exe_addr;
            res_bad_we = 1'b1;
        end
    end

`ifdef EXC_INT_EN
    assign int_hit = eval && !res_exc && bus.status_ie && (|bus.int_pending);
`else
    assign int_hit = 1'b0;
`endif

    assign take      = (eval && res_exc) || int_hit;
    assign eret_fire = eval && bus.eret && !res_exc && !int_hit;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (take) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (bus.exc_ack) begin
                    state_d = ST_DRAIN;
                    cnt_d   = 4'(FLUSH_CYCLES);
                end
            end
            ST_DRAIN: begin
                if (cnt_q <= 4'd1) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Slot only advances while collecting; a taken exception or REQ/DRAIN empties it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_valid  <= 1'b0;
            slot_exc    <= 1'b0;
            slot_bad_we <= 1'b0;
            slot_pc     <= 32'd0;
            slot_badv   <= 32'd0;
            slot_code   <= EXC_INT;
        end else if ((state_q != ST_IDLE) || take) begin
            slot_valid  <= 1'b0;
            slot_exc    <= 1'b0;
            slot_bad_we <= 1'b0;
        end else if (!bus.stall) begin
            slot_valid  <= bus.id_valid;
            slot_exc    <= bus.id_valid && id_exc;
            slot_bad_we <= bus.id_valid && bus.id_pc_misalign;
            slot_pc     <= bus.id_pc;
            slot_badv   <= id_badv;
            slot_code   <= id_code;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            code_q   <= EXC_INT;
            epc_q    <= 32'd0;
            badv_q   <= 32'd0;
            bad_we_q <= 1'b0;
            eret_q   <= 1'b0;
        end else begin
            eret_q <= eret_fire;
            if (take) begin
                code_q   <= res_exc ? res_code   : EXC_INT;
                epc_q    <= slot_pc;
                badv_q   <= res_exc ? res_badv   : 32'd0;
                bad_we_q <= res_exc ? res_bad_we : 1'b0;
            end
        end
    end

    assign bus.exc_req      = (state_q == ST_REQ);
    assign bus.exc_flush    = (state_q != ST_IDLE);
    assign bus.exc_state    = state_q;
    assign bus.exc_code     = code_q;
    assign bus.exc_epc      = epc_q;
    assign bus.exc_badvaddr = badv_q;
    assign bus.exc_bad_we   = bad_we_q;
    assign bus.eret_req     = eret_q;
endmodule

// File: tb/tb_exc_collect.sv
// Bench for exc_collect: directed scenarios plus randomized traffic against a cycle-level model.
module tb_exc_collect;
    localparam int FLUSH = 2;

    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    exc_collect_if bus();

    exc_collect #(.FLUSH_CYCLES(FLUSH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: slot contents, pending request, remaining drain cycles.
    bit          ms_v, ms_exc;
    logic [31:0] ms_pc, ms_badv;
    logic [4:0]  ms_code;
    bit          m_req, m_bwe, m_eret;
    int          m_drain;
    logic [4:0]  m_code;
    logic [31:0] m_epc, m_badv;

    function automatic void model_reset();
        ms_v = 0; ms_exc = 0; ms_pc = 0; ms_badv = 0; ms_code = 0;
        m_req = 0; m_bwe = 0; m_eret = 0; m_drain = 0;
        m_code = 0; m_epc = 0; m_badv = 0;
    endfunction

    function automatic void model_step();
        logic [4:0] id_codes [4] = '{5'h04, 5'h0a, 5'h08, 5'h09};
        logic [4:0] ex_codes [3] = '{5'h0c, 5'h04, 5'h05};
        bit fid [4];
        bit fex [3];
        bit took = 0;
        bit n_eret = 0;
        bit irq = 0;
        fid = '{bus.id_pc_misalign, bus.id_ri, bus.id_syscall, bus.id_break};
        fex = '{bus.exe_overflow, bus.exe_adel, bus.exe_ades};
        if (m_req) begin
            if (bus.exc_ack) begin
                m_req = 0;
                m_drain = FLUSH;
            end
            ms_v = 0; ms_exc = 0;
        end else if (m_drain > 0) begin
            m_drain = m_drain - 1;
            ms_v = 0; ms_exc = 0;
        end else if (!bus.stall) begin
            if (ms_v) begin
                if (ms_exc) begin
                    took = 1; m_code = ms_code; m_badv = ms_badv; m_bwe = (ms_code == 5'h04);
                end else begin
                    for (int i = 0; i < 3; i++) begin
                        if (fex[i] && !took) begin
                            took = 1; m_code = ex_codes[i];
                            m_badv = (i == 0) ? 32'd0 : bus.exe_addr;
                            m_bwe = (i != 0);
                        end
                    end
                end
`ifdef EXC_INT_EN
                irq = !took && bus.status_ie && (bus.int_pending != 6'd0);
`endif
                if (irq) begin
                    took = 1; m_code = 5'h00; m_badv = 0; m_bwe = 0;
                end
                if (took) begin
                    m_req = 1; m_epc = ms_pc;
                end else begin
                    n_eret = bus.eret;
                end
            end
            if (took) begin
                ms_v = 0; ms_exc = 0;
            end else begin
                ms_v = bus.id_valid; ms_pc = bus.id_pc;
                ms_exc = 0; ms_code = 0; ms_badv = 0;
                if (bus.id_valid) begin
                    for (int i = 0; i < 4; i++) begin
                        if (fid[i] && !ms_exc) begin
                            ms_exc = 1; ms_code = id_codes[i];
                            ms_badv = (i == 0) ? bus.id_pc : 32'd0;
                        end
                    end
                end
            end
        end
        m_eret = n_eret;
    endfunction

    task automatic tick();
        if (reset) model_step();
        else model_reset();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.stall = 0; bus.id_valid = 0; bus.id_pc = 0;
        bus.id_pc_misalign = 0; bus.id_ri = 0; bus.id_syscall = 0; bus.id_break = 0;
        bus.exe_overflow = 0; bus.exe_adel = 0; bus.exe_ades = 0; bus.exe_addr = 0;
        bus.eret = 0; bus.exc_ack = 0;
`ifdef EXC_INT_EN
        bus.int_pending = 0; bus.status_ie = 0;
`endif
    endtask

    task automatic load_slot(input logic [31:0] pc);
        bus.id_valid = 1; bus.id_pc = pc;
        tick();
        bus.id_valid = 0; bus.id_pc = 0;
    endtask

    task automatic finish_req();
        bus.exc_ack = 1;
        tick();
        bus.exc_ack = 0;
        repeat (FLUSH) tick();
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 0;
        model_reset();
        #1;
        checks++; if ({bus.exc_req, bus.exc_flush, bus.eret_req, bus.exc_bad_we} !== 4'b0) begin
            errors++; $display("FAIL reset_flags: got %b want 0000", {bus.exc_req, bus.exc_flush, bus.eret_req, bus.exc_bad_we}); end
        checks++; if (bus.exc_state !== 2'd0) begin
            errors++; $display("FAIL reset_state: got %0d want 0", bus.exc_state); end
        @(negedge clk); @(negedge clk);
        reset = 1;
        bus.exc_ack = 1;
        tick();
        bus.exc_ack = 0;
        checks++; if (bus.exc_state !== 2'd0 || bus.exc_req !== 1'b0) begin
            errors++; $display("FAIL idle_ack_ignored: got state %0d req %b want 0 0", bus.exc_state, bus.exc_req); end
    endtask

    task automatic test_id_ri();
        bus.id_valid = 1; bus.id_pc = 32'hBFC00010; bus.id_ri = 1;
        tick();
        bus.id_valid = 0; bus.id_pc = 0; bus.id_ri = 0;
        checks++; if (bus.exc_req !== 1'b0) begin
            errors++; $display("FAIL ri_early: got req %b want 0 at n+1", bus.exc_req); end
        tick();
        checks++; if (bus.exc_req !== 1'b1 || bus.exc_flush !== 1'b1 || bus.exc_state !== 2'd1) begin
            errors++; $display("FAIL ri_req: got req %b flush %b state %0d want 1 1 1", bus.exc_req, bus.exc_flush, bus.exc_state); end
        checks++; if (bus.exc_code !== 5'h0a || bus.exc_epc !== 32'hBFC00010 || bus.exc_bad_we !== 1'b0) begin
            errors++; $display("FAIL ri_fields: got code %h epc %h bwe %b want 0a bfc00010 0", bus.exc_code, bus.exc_epc, bus.exc_bad_we); end
        tick(); tick();
        checks++; if (bus.exc_req !== 1'b1) begin
            errors++; $display("FAIL ri_hold: got req %b want 1", bus.exc_req); end
        bus.exc_ack = 1;
        tick();
        bus.exc_ack = 0;
        checks++; if (bus.exc_req !== 1'b0 || bus.exc_flush !== 1'b1 || bus.exc_state !== 2'd2) begin
            errors++; $display("FAIL ri_drain1: got req %b flush %b state %0d want 0 1 2", bus.exc_req, bus.exc_flush, bus.exc_state); end
        tick();
        checks++; if (bus.exc_flush !== 1'b1 || bus.exc_state !== 2'd2) begin
            errors++; $display("FAIL ri_drain2: got flush %b state %0d want 1 2", bus.exc_flush, bus.exc_state); end
        tick();
        checks++; if (bus.exc_flush !== 1'b0 || bus.exc_state !== 2'd0) begin
            errors++; $display("FAIL ri_idle: got flush %b state %0d want 0 0", bus.exc_flush, bus.exc_state); end
    endtask

    task automatic test_priority();
        bus.id_valid = 1; bus.id_pc = 32'h00400006; bus.id_pc_misalign = 1; bus.id_ri = 1;
        tick();
        bus.id_valid = 0; bus.id_pc = 0; bus.id_pc_misalign = 0; bus.id_ri = 0;
        bus.exe_overflow = 1;
        tick();
        bus.exe_overflow = 0;
        checks++; if (bus.exc_code !== 5'h04 || bus.exc_badvaddr !== 32'h00400006 || bus.exc_bad_we !== 1'b1) begin
            errors++; $display("FAIL prio_fields: got code %h badv %h bwe %b want 04 00400006 1", bus.exc_code, bus.exc_badvaddr, bus.exc_bad_we); end
        finish_req();
    endtask

    task automatic test_stall_ades();
        load_slot(32'h00400040);
        bus.stall = 1; bus.exe_ades = 1; bus.exe_addr = 32'h00000003;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bus.exc_req !== 1'b0) begin
                errors++; $display("FAIL stall_noreq%0d: got req %b want 0", i, bus.exc_req); end
        end
        bus.stall = 0;
        tick();
        bus.exe_ades = 0; bus.exe_addr = 0;
        checks++; if (bus.exc_req !== 1'b1 || bus.exc_code !== 5'h05 || bus.exc_badvaddr !== 32'h3 || bus.exc_epc !== 32'h00400040) begin
            errors++; $display("FAIL ades_req: got req %b code %h badv %h epc %h want 1 05 00000003 00400040", bus.exc_req, bus.exc_code, bus.exc_badvaddr, bus.exc_epc); end
        finish_req();
        tick(); tick();
        checks++; if (bus.exc_req !== 1'b0 || bus.exc_state !== 2'd0) begin
            errors++; $display("FAIL ades_nodup: got req %b state %0d want 0 0", bus.exc_req, bus.exc_state); end
    endtask

    task automatic test_eret();
        load_slot(32'h80000180);
        bus.eret = 1;
        tick();
        bus.eret = 0;
        checks++; if (bus.eret_req !== 1'b1) begin
            errors++; $display("FAIL eret_pulse: got %b want 1", bus.eret_req); end
        tick();
        checks++; if (bus.eret_req !== 1'b0) begin
            errors++; $display("FAIL eret_width: got %b want 0", bus.eret_req); end
        load_slot(32'h80000184);
        bus.eret = 1; bus.exe_overflow = 1;
        tick();
        bus.eret = 0; bus.exe_overflow = 0;
        checks++; if (bus.eret_req !== 1'b0 || bus.exc_req !== 1'b1 || bus.exc_code !== 5'h0c) begin
            errors++; $display("FAIL eret_ov: got eret %b req %b code %h want 0 1 0c", bus.eret_req, bus.exc_req, bus.exc_code); end
        finish_req();
    endtask

    task automatic test_reset_mid_req();
        load_slot(32'h00400100);
        bus.exe_overflow = 1;
        tick();
        bus.exe_overflow = 0;
        reset = 0;
        #1;
        checks++; if ({bus.exc_req, bus.exc_flush, bus.eret_req, bus.exc_bad_we} !== 4'b0 || bus.exc_state !== 2'd0) begin
            errors++; $display("FAIL midreq_reset: got flags %b state %0d want 0000 0", {bus.exc_req, bus.exc_flush, bus.eret_req, bus.exc_bad_we}, bus.exc_state); end
        checks++; if (bus.exc_code !== 5'h0 || bus.exc_epc !== 32'h0 || bus.exc_badvaddr !== 32'h0) begin
            errors++; $display("FAIL midreq_fields: got code %h epc %h badv %h want 0 0 0", bus.exc_code, bus.exc_epc, bus.exc_badvaddr); end
        tick();
        reset = 1;
        load_slot(32'h00400200);
        bus.exe_overflow = 1;
        tick();
        bus.exe_overflow = 0;
        checks++; if (bus.exc_req !== 1'b1 || bus.exc_code !== 5'h0c || bus.exc_epc !== 32'h00400200) begin
            errors++; $display("FAIL after_reset_ov: got req %b code %h epc %h want 1 0c 00400200", bus.exc_req, bus.exc_code, bus.exc_epc); end
        finish_req();
    endtask

`ifdef EXC_INT_EN
    task automatic test_interrupt();
        load_slot(32'h80000100);
        bus.int_pending = 6'b000001; bus.status_ie = 1;
        tick();
        bus.int_pending = 0; bus.status_ie = 0;
        checks++; if (bus.exc_req !== 1'b1 || bus.exc_code !== 5'h00 || bus.exc_epc !== 32'h80000100 || bus.exc_bad_we !== 1'b0) begin
            errors++; $display("FAIL irq_req: got req %b code %h epc %h bwe %b want 1 00 80000100 0", bus.exc_req, bus.exc_code, bus.exc_epc, bus.exc_bad_we); end
        finish_req();
        load_slot(32'h80000104);
        bus.int_pending = 6'b000001; bus.status_ie = 0;
        tick();
        bus.int_pending = 0;
        checks++; if (bus.exc_req !== 1'b0) begin
            errors++; $display("FAIL irq_masked: got req %b want 0", bus.exc_req); end
    endtask
`endif

    task automatic test_random();
        logic [1:0] exp_state;
        for (int c = 0; c < 600; c++) begin
            exp_state = m_req ? 2'd1 : ((m_drain > 0) ? 2'd2 : 2'd0);
            checks++; if (bus.exc_state !== exp_state) begin
                errors++; $display("FAIL rnd_state c%0d: got %0d want %0d", c, bus.exc_state, exp_state); end
            checks++; if (bus.exc_req !== m_req || bus.exc_flush !== (exp_state != 2'd0)) begin
                errors++; $display("FAIL rnd_reqflush c%0d: got %b%b want %b%b", c, bus.exc_req, bus.exc_flush, m_req, exp_state != 2'd0); end
            checks++; if (bus.eret_req !== m_eret) begin
                errors++; $display("FAIL rnd_eret c%0d: got %b want %b", c, bus.eret_req, m_eret); end
            if (m_req) begin
                checks++; if (bus.exc_code !== m_code || bus.exc_epc !== m_epc || bus.exc_badvaddr !== m_badv || bus.exc_bad_we !== m_bwe) begin
                    errors++; $display("FAIL rnd_fields c%0d: got %h %h %h %b want %h %h %h %b", c,
                        bus.exc_code, bus.exc_epc, bus.exc_badvaddr, bus.exc_bad_we, m_code, m_epc, m_badv, m_bwe); end
            end
            bus.stall          = ($urandom_range(0, 4) == 0);
            bus.id_valid       = ($urandom_range(0, 9) < 7);
            bus.id_pc          = $urandom & 32'hFFFF_FFFC;
            bus.id_pc_misalign = ($urandom_range(0, 19) == 0);
            bus.id_ri          = ($urandom_range(0, 19) == 0);
            bus.id_syscall     = ($urandom_range(0, 19) == 0);
            bus.id_break       = ($urandom_range(0, 19) == 0);
            bus.exe_overflow   = ($urandom_range(0, 19) == 0);
            bus.exe_adel       = ($urandom_range(0, 19) == 0);
            bus.exe_ades       = ($urandom_range(0, 19) == 0);
            bus.exe_addr       = $urandom;
            bus.eret           = ($urandom_range(0, 9) == 0);
            bus.exc_ack        = ($urandom_range(0, 2) == 0);
`ifdef EXC_INT_EN
            bus.int_pending    = ($urandom_range(0, 14) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
            bus.status_ie      = ($urandom_range(0, 1) == 1);
`endif
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 0;
        clear_inputs();
        model_reset();
        @(negedge clk);
        test_reset();
        test_id_ri();
        test_priority();
        test_stall_ades();
        test_eret();
        test_reset_mid_req();
`ifdef EXC_INT_EN
        test_interrupt();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/exc_collect.md
# exc_collect

Exception collection and arbitration stage that sits directly upstream of the coprocessor-0 register block. It gathers exception flags raised in ID and EXE and carries them alongside the instruction through a one-entry EXE slot. It then prioritises them per instruction and hands the coprocessor a single held request carrying cause code, EPC and bad address. A small request/drain state machine runs until the coprocessor acknowledges and the pipeline flush completes.

## Interface
- FLUSH_CYCLES, 2, cycles `exc_flush` stays high after `exc_ack` (1..15)
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- stall  in  1  pipeline hold; EXE slot keeps contents, no detection
- id_valid  in  1  ID holds a real instruction
- id_pc  in  32  PC of ID instruction
- id_pc_misalign  in  1  fetch address error (AdEL)
- id_ri  in  1  reserved instruction
- id_syscall  in  1  syscall
- id_break  in  1  break
- exe_overflow  in  1  arithmetic overflow of EXE instruction
- exe_adel / exe_ades  in  1  load / store address error
- exe_addr  in  32  effective address in EXE
- eret  in  1  EXE instruction is eret
- exc_ack  in  1  coprocessor has written Cause/EPC/Status
- int_pending  in  6  external interrupt lines (only with EXC_INT_EN)
- status_ie  in  1  Status.IE (only with EXC_INT_EN)
- exc_req  out  1  exception request, held until ack
- exc_code  out  5  Cause.ExcCode
- exc_epc  out  32  faulting PC
- exc_badvaddr  out  32  bad address
- exc_bad_we  out  1  write BadVAddr (AdEL/AdES only)
- exc_flush  out  1  flush IF/ID/EXE
- eret_req  out  1  one-cycle eret redirect pulse
- exc_state  out  2  FSM state (0 IDLE, 1 REQ, 2 DRAIN)

## Operation
- ID priority, resolved on the clock edge into the EXE slot: pc_misalign (0x04, badv=id_pc), then ri (0x0a), then syscall (0x08), then break (0x09). If none fires, the slot holds valid with no exception.
- The EXE slot loads `{id_valid, id_pc, code, badv, has_exc}` on each edge with stall=0 in IDLE.
- id_valid=0 loads a bubble. Flags on a bubble are ignored.
- EXE resolution is combinational, and is evaluated only when the slot is valid, stall=0 and state is IDLE.
  - A slot exception always wins.
  - Otherwise: overflow (0x0c), then adel (0x04, badv=exe_addr), then ades (0x05, badv=exe_addr).
- epc is always the slot PC.
- FSM:
  - IDLE→REQ on a resolved exception. `exc_code`, `exc_epc`, `exc_badvaddr` and `exc_bad_we` are latched and the slot is cleared.
  - REQ: `exc_req`=1 and `exc_flush`=1. Outputs stay stable regardless of stall or inputs. On `exc_ack`, go to DRAIN and load counter=FLUSH_CYCLES.
  - DRAIN: `exc_flush`=1 and the slot is held empty. All ID/EXE flags and eret are ignored. The counter decrements each cycle; when it reaches 1, return to IDLE.
- eret: valid slot, no resolved exception, IDLE and stall=0 gives `eret_req` high for one cycle. An exception on the same instruction suppresses eret.
- Reset (any time, including mid-REQ/DRAIN) forces:
  - state IDLE and slot empty;
  - all outputs 0, counter 0.

## Timing
- ID flag in cycle n, stall=0: captured at edge n+1. The exception resolves in cycle n+1, and `exc_req` is high from cycle n+2.
- EXE-only exception in cycle n gives `exc_req` in cycle n+1.
- `exc_ack` sampled high in REQ at edge k: `exc_req` drops in cycle k. `exc_flush` stays high for FLUSH_CYCLES further cycles, and IDLE begins at cycle k+FLUSH_CYCLES.
- `exc_ack` while IDLE/DRAIN is ignored.
- `eret_req` is registered, one cycle after the eret is in EXE.
- A stall held for m cycles delays detection by exactly m cycles, and no request is duplicated.

## Configuration
- EXC_INT_EN defined:
  - adds ports `int_pending` and `status_ie`;
  - in IDLE with stall=0, `status_ie`=1 and `|int_pending` with a valid slot that has no resolved exception, raises code 0x00 with epc = slot PC and `exc_bad_we`=0;
  - interrupts rank below every exception and suppress eret.
- EXC_INT_EN undefined: the ports and interrupt logic are absent, and the behaviour is otherwise identical.

## Test plan
- ID ri=1 with id_pc=0xBFC00010, ack 3 cycles later: `exc_req` appears at n+2 with code 0x0a, epc 0xBFC00010, bad_we 0. After ack, flush lasts 2 cycles, then IDLE.
- Same instruction with id_pc_misalign=1 and id_ri=1, followed by exe_overflow in EXE: code 0x04, badvaddr=id_pc, bad_we 1.
- exe_ades with exe_addr=0x00000003 while stall is high for 3 cycles: no request during stall. A single request with code 0x05 and badvaddr 0x3 follows release.
- eret with no exception: `eret_req` pulses exactly 1 cycle. The same eret with overflow gives code 0x0c and no `eret_req`.
- Reset pulled low mid-REQ: all outputs 0 immediately and state 0. The next overflow after release is handled normally.
- EXC_INT_EN, `int_pending`=6'b000001, `status_ie`=1, clean slot pc=0x80000100: code 0x00, epc 0x80000100. With status_ie=0, no request.
